// File: rtl/fnn_mac_scheduler.sv
// Sequencer that walks one shared MAC over every sample, layer, neuron and input
// of a small fully-connected network, and tallies correct classifications.
module fnn_mac_scheduler #(
    parameter int N_SAMPLE = 750,
    parameter int N_LAYER  = 3,
    parameter int N_NEURON = 10,
    parameter int N_IN0    = 62
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       eq,
    output logic       busy,
    output logic       done,
    output logic       read_mem_inp,
    output logic       read_mem_label,
    output logic       acc_clr,
    output logic       mac_en,
    output logic       act_ld,
    output logic [9:0] sample_idx,
    output logic [1:0] layer_idx,
    output logic [3:0] neuron_idx,
    output logic [5:0] in_idx,
    output logic [9:0] correct_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CLR   = 3'd2,
        S_MAC   = 3'd3,
        S_WB    = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [9:0] SAMPLE_LAST = 10'(N_SAMPLE - 1);
    localparam logic [1:0] LAYER_LAST  = 2'(N_LAYER - 1);
    localparam logic [3:0] NEURON_LAST = 4'(N_NEURON - 1);
    localparam logic [5:0] IN0_LAST    = 6'(N_IN0 - 1);
    localparam logic [5:0] INN_LAST    = 6'(N_NEURON - 1);
    localparam logic [9:0] CNT_MAX     = 10'd1023;

    // Output vector order: {busy, done, read_mem_inp, read_mem_label, acc_clr, mac_en, act_ld}
    function automatic logic [6:0] strobes_for(input state_t s);
        logic [6:0] v;
        case (s)
            S_FETCH: v = 7'b1010000;
            S_CLR:   v = 7'b1000100;
            S_MAC:   v = 7'b1000010;
            S_WB:    v = 7'b1000001;
            S_CHECK: v = 7'b1001000;
            S_DONE:  v = 7'b0100000;
            default: v = 7'b0000000;
        endcase
        return v;
    endfunction

    state_t     r_state;
    logic [6:0] r_out;
    logic [9:0] r_sample;
    logic [1:0] r_layer;
    logic [3:0] r_neuron;
    logic [5:0] r_in;
    logic [9:0] r_correct;
    logic       w_in_last;

    // Layer 0 consumes the raw inputs; deeper layers consume the previous layer's neurons.
    assign w_in_last = (r_layer == 2'd0) ? (r_in == IN0_LAST) : (r_in == INN_LAST);

    // Sequencer: state, indices, tally and the strobes of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_out     <= 7'b0000000;
            r_sample  <= 10'd0;
            r_layer   <= 2'd0;
            r_neuron  <= 4'd0;
            r_in      <= 6'd0;
            r_correct <= 10'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_out     <= strobes_for(S_FETCH);
                        r_sample  <= 10'd0;
                        r_layer   <= 2'd0;
                        r_neuron  <= 4'd0;
                        r_in      <= 6'd0;
                        r_correct <= 10'd0;
                    end else begin
                        r_out <= strobes_for(r_state);
                    end
                end
                S_FETCH: begin
                    r_state <= S_CLR;
                    r_out   <= strobes_for(S_CLR);
                end
                S_CLR: begin
                    r_in    <= 6'd0;
                    r_state <= S_MAC;
                    r_out   <= strobes_for(S_MAC);
                end
                S_MAC: begin
                    if (w_in_last) begin
                        r_state <= S_WB;
                        r_out   <= strobes_for(S_WB);
                    end else begin
                        r_in  <= r_in + 6'd1;
                        r_out <= strobes_for(S_MAC);
                    end
                end
                S_WB: begin
                    if (r_neuron != NEURON_LAST) begin
                        r_neuron <= r_neuron + 4'd1;
                        r_state  <= S_CLR;
                        r_out    <= strobes_for(S_CLR);
                    end else if (r_layer != LAYER_LAST) begin
                        r_neuron <= 4'd0;
                        r_layer  <= r_layer + 2'd1;
                        r_state  <= S_CLR;
                        r_out    <= strobes_for(S_CLR);
                    end else begin
                        r_state <= S_CHECK;
                        r_out   <= strobes_for(S_CHECK);
                    end
                end
                S_CHECK: begin
                    if (eq && (r_correct != CNT_MAX)) begin
                        r_correct <= r_correct + 10'd1;
                    end else begin
                        r_correct <= r_correct;
                    end
                    if (r_sample != SAMPLE_LAST) begin
                        r_sample <= r_sample + 10'd1;
                        r_layer  <= 2'd0;
                        r_neuron <= 4'd0;
                        r_state  <= S_FETCH;
                        r_out    <= strobes_for(S_FETCH);
                    end else begin
                        r_state <= S_DONE;
                        r_out   <= strobes_for(S_DONE);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_out   <= 7'b0000000;
                end
            endcase
        end
    end

    assign {busy, done, read_mem_inp, read_mem_label, acc_clr, mac_en, act_ld} = r_out;
    assign sample_idx  = r_sample;
    assign layer_idx   = r_layer;
    assign neuron_idx  = r_neuron;
    assign in_idx      = r_in;
    assign correct_cnt = r_correct;

endmodule

// File: tb/tb_fnn_mac_scheduler.sv
// Bench for fnn_mac_scheduler: expected per-cycle trace built from nested loops over
// samples/layers/neurons/inputs, with random eq and random start re-pulses.
module tb_fnn_mac_scheduler;

    localparam int NS  = 2;
    localparam int NL  = 2;
    localparam int NN  = 2;
    localparam int NI0 = 3;

    // {busy, done, read_mem_inp, read_mem_label, acc_clr, mac_en, act_ld}
    localparam logic [6:0] ST_FETCH = 7'b1010000;
    localparam logic [6:0] ST_CLR   = 7'b1000100;
    localparam logic [6:0] ST_MAC   = 7'b1000010;
    localparam logic [6:0] ST_WB    = 7'b1000001;
    localparam logic [6:0] ST_CHECK = 7'b1001000;
    localparam logic [6:0] ST_DONE  = 7'b0100000;

    typedef struct packed {
        logic [6:0] st;
        logic [9:0] s;
        logic [1:0] l;
        logic [3:0] n;
        logic [5:0] i;
    } ent_t;

    logic       clk, rst, start, eq;
    logic       busy, done, read_mem_inp, read_mem_label, acc_clr, mac_en, act_ld;
    logic [9:0] sample_idx, correct_cnt;
    logic [1:0] layer_idx;
    logic [3:0] neuron_idx;
    logic [5:0] in_idx;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t exp_q[$];

    fnn_mac_scheduler #(
        .N_SAMPLE(NS), .N_LAYER(NL), .N_NEURON(NN), .N_IN0(NI0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .eq(eq),
        .busy(busy), .done(done),
        .read_mem_inp(read_mem_inp), .read_mem_label(read_mem_label),
        .acc_clr(acc_clr), .mac_en(mac_en), .act_ld(act_ld),
        .sample_idx(sample_idx), .layer_idx(layer_idx),
        .neuron_idx(neuron_idx), .in_idx(in_idx), .correct_cnt(correct_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {busy, done, read_mem_inp, read_mem_label, acc_clr, mac_en, act_ld};
    endfunction

    // One entry per busy cycle, straight from the nested loop structure of the network.
    task automatic build_trace();
        ent_t e;
        int   cnt;
        exp_q.delete();
        for (int s = 0; s < NS; s++) begin
            e = '{ST_FETCH, 10'(s), 2'd0, 4'd0, 6'd0};
            exp_q.push_back(e);
            for (int l = 0; l < NL; l++) begin
                cnt = (l == 0) ? NI0 : NN;
                for (int n = 0; n < NN; n++) begin
                    e = '{ST_CLR, 10'(s), 2'(l), 4'(n), 6'd0};
                    exp_q.push_back(e);
                    for (int i = 0; i < cnt; i++) begin
                        e = '{ST_MAC, 10'(s), 2'(l), 4'(n), 6'(i)};
                        exp_q.push_back(e);
                    end
                    e = '{ST_WB, 10'(s), 2'(l), 4'(n), 6'd0};
                    exp_q.push_back(e);
                end
            end
            e = '{ST_CHECK, 10'(s), 2'(NL - 1), 4'(NN - 1), 6'd0};
            exp_q.push_back(e);
        end
    endtask

    // eq_mode: 0 random, 1 always high, 2 high only in the last CHECK, 3 low in CHECK.
    task automatic run_once(input int eq_mode, input bit spam);
        int   exp_cnt;
        ent_t e;
        logic v_eq;
        exp_cnt = 0;
        build_trace();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            e = exp_q[k];
            chk("strobes", 32'(strobes()), 32'(e.st));
            chk("sample_idx", 32'(sample_idx), 32'(e.s));
            chk("layer_idx", 32'(layer_idx), 32'(e.l));
            chk("neuron_idx", 32'(neuron_idx), 32'(e.n));
            if (e.st == ST_MAC) chk("in_idx", 32'(in_idx), 32'(e.i));
            chk("correct_cnt", 32'(correct_cnt), 32'(exp_cnt));
            case (eq_mode)
                1:       v_eq = 1'b1;
                2:       v_eq = (e.st == ST_CHECK) ? (e.s == 10'(NS - 1)) : 1'($urandom);
                3:       v_eq = (e.st == ST_CHECK) ? 1'b0 : 1'($urandom);
                default: v_eq = 1'($urandom);
            endcase
            eq = v_eq;
            if (e.st == ST_CHECK && v_eq) exp_cnt++;
            start = spam ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("done_strobes", 32'(strobes()), 32'(ST_DONE));
            chk("done_cnt", 32'(correct_cnt), 32'(exp_cnt));
            chk("done_sample", 32'(sample_idx), 32'(NS - 1));
            eq = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {strobes(), sample_idx, layer_idx, neuron_idx, in_idx, correct_cnt}, 32'd0);
    endtask

    initial begin
        logic found;
        rst   = 1'b1;
        start = 1'b0;
        eq    = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_state");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            eq = 1'($urandom);
            @(negedge clk);
            chk("idle_strobes", 32'(strobes()), 32'd0);
        end

        run_once(0, 1'b0);
        run_once(1, 1'b0);
        run_once(2, 1'b1);
        run_once(3, 1'b0);

        // Asynchronous reset in the middle of sample 1's MAC phase.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (mac_en && sample_idx == 10'd1) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_mac_s1", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        chk_all_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 32'(strobes()), 32'd0);
        run_once(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fnn_mac_scheduler.md
# fnn_mac_scheduler

Sequencer for a time-multiplexed FNN datapath. It steps one shared multiply-accumulate unit over every sample, layer, neuron and input, so that a single MAC evaluates the full 3-layer, 10-neuron network. It generates the read, clear, accumulate and write-back strobes, and counts correct classifications against the label memory. It sits between the input, weight and label memories and the MAC/activation datapath, and replaces per-neuron parallel hardware.

## Interface
- N_SAMPLE, 750: test samples per run.
- N_LAYER, 3: layers.
- N_NEURON, 10: neurons per layer. This is also the input count of layers 1..N_LAYER-1.
- N_IN0, 62: input count of layer 0.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a run; sampled only in IDLE or DONE.
- eq  input  1  high when the datapath's argmax equals the label; sampled in CHECK.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high while in DONE.
- read_mem_inp  output  1  input-memory read of sample `sample_idx`.
- read_mem_label  output  1  label-memory read of sample `sample_idx`.
- acc_clr  output  1  loads the accumulator with the bias of (`layer_idx`, `neuron_idx`).
- mac_en  output  1  accumulates weight(`layer_idx`, `neuron_idx`, `in_idx`) × input(`in_idx`).
- act_ld  output  1  writes the activated accumulator to activation register (`layer_idx`, `neuron_idx`).
- sample_idx  output  10  current sample.
- layer_idx  output  2  current layer.
- neuron_idx  output  4  current neuron.
- in_idx  output  6  current input.
- correct_cnt  output  10  correctly classified samples in the current or last run.

## Operation
- States: IDLE, FETCH, CLR, MAC, WB, CHECK, DONE. The state is registered. All strobes are Moore outputs decoded from state only. All indices are registers.
- IDLE or DONE, with start=1:
  - Next state is FETCH.
  - sample_idx, layer_idx, neuron_idx, in_idx and correct_cnt clear to 0.
- FETCH: read_mem_inp=1. Next state is CLR.
- CLR: acc_clr=1, in_idx=0. Next state is MAC.
- MAC: mac_en=1. The input count is N_IN0 when layer_idx=0, otherwise N_NEURON.
  - in_idx < count−1: increment in_idx and stay in MAC.
  - in_idx = count−1: go to WB.
- WB: act_ld=1. Transitions:
  - neuron_idx < N_NEURON−1: increment neuron_idx and go to CLR.
  - Last neuron, layer_idx < N_LAYER−1: clear neuron_idx, increment layer_idx, go to CLR.
  - Last neuron of last layer: go to CHECK.
- CHECK: read_mem_label=1.
  - If eq=1, correct_cnt increments, saturating at 1023.
  - sample_idx < N_SAMPLE−1: increment sample_idx, clear layer_idx and neuron_idx, go to FETCH.
  - Otherwise go to DONE.
- DONE: done=1. All indices and correct_cnt hold. Stays in DONE until start.
- start is ignored while busy. eq is ignored outside CHECK.
- All strobes are mutually exclusive; at most one of them is high in any cycle.

## Timing
- Reset (asynchronous, any state, including mid-run):
  - state goes to IDLE.
  - All indices and correct_cnt go to 0.
  - All strobes, busy and done go to 0.
- Start latency: start high at edge k puts FETCH at cycle k+1, with busy=1 from cycle k+1.
- Cycles per neuron = n_in + 2 (CLR + MAC×n_in + WB).
- Cycles per sample = 2 + N_NEURON·(N_IN0+2) + (N_LAYER−1)·N_NEURON·(N_NEURON+2). With the defaults this is 2 + 640 + 240 = 882.
- Total run = N_SAMPLE × per-sample cycles, followed by DONE.
- Memories are combinational-read. The datapath captures read data on the edge that ends the strobe cycle.
- Index values are valid during the cycle whose strobe uses them. in_idx changes only on MAC→MAC and CLR→MAC edges.

## Test plan
All scenarios use N_SAMPLE=2, N_LAYER=2, N_NEURON=2, N_IN0=3. Per-sample length is 2+10+8 = 20 cycles.

- Reset then start pulse:
  - FETCH is at cycle 1.
  - acc_clr, then mac_en for 3 cycles with in_idx 0,1,2, then act_ld (layer 0, neuron 0).
  - done rises after exactly 40 busy cycles.
- Layer-1 check: MAC runs exactly 2 cycles per neuron (in_idx 0,1), never 3.
- eq tied high: correct_cnt=2 at DONE. eq high only during the second CHECK: correct_cnt=1. eq toggling outside CHECK leaves correct_cnt unchanged.
- start re-pulsed while busy: ignored, and the trace is identical to a single start.
- From DONE with correct_cnt=2, start clears correct_cnt and sample_idx to 0 on the next edge.
- rst asserted mid-MAC of sample 1: all outputs are 0 immediately, without waiting for a clock edge. After release, start re-runs from sample 0.
